// File: rtl/ysyx_25010008_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Holds a single registered result until the winning requester consumes it.
module ysyx_25010008_alu_arbiter #(
   parameter logic FIRST_PRIO = 1'b0,
   parameter int   XLEN       = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [7:0]      req0_opcode,
   input  logic [XLEN-1:0] req0_op1,
   input  logic [XLEN-1:0] req0_op2,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [7:0]      req1_opcode,
   input  logic [XLEN-1:0] req1_op1,
   input  logic [XLEN-1:0] req1_op2,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic [7:0]      alu_opcode,
   output logic [XLEN-1:0] alu_operand1,
   output logic [XLEN-1:0] alu_operand2,
   input  logic [XLEN-1:0] alu_result
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t          r_state;
   logic            r_rsp_id;
   logic            r_prio;
   logic [XLEN-1:0] r_rsp_result;

   logic            w_rsp_fire;
   logic            w_can_accept;
   logic            w_gnt_vld;
   logic            w_gnt_id;
   logic            w_accept;

   assign rsp0_valid = (r_state == S_HOLD) & ~r_rsp_id;
   assign rsp1_valid = (r_state == S_HOLD) &  r_rsp_id;
   assign rsp_result = r_rsp_result;

   // Draining the held result frees the slot in the same cycle.
   assign w_rsp_fire   = r_rsp_id ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
   assign w_can_accept = (r_state == S_IDLE) | w_rsp_fire;

   assign w_gnt_vld = req0_valid | req1_valid;
   assign w_gnt_id  = (req0_valid & req1_valid) ? r_prio : req1_valid;

   assign req0_ready = w_can_accept & w_gnt_vld & ~w_gnt_id;
   assign req1_ready = w_can_accept & w_gnt_vld &  w_gnt_id;
   assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   // The ALU sees the granted request even while the result slot is still busy.
   always_comb begin
      alu_opcode   = '0;
      alu_operand1 = '0;
      alu_operand2 = '0;
      if (w_gnt_vld) begin
         if (w_gnt_id) begin
            alu_opcode   = req1_opcode;
            alu_operand1 = req1_op1;
            alu_operand2 = req1_op2;
         end else begin
            alu_opcode   = req0_opcode;
            alu_operand1 = req0_op1;
            alu_operand2 = req0_op2;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_rsp_id     <= 1'b0;
         r_prio       <= FIRST_PRIO;
         r_rsp_result <= '0;
      end else if (w_accept) begin
         r_state      <= S_HOLD;
         r_rsp_id     <= w_gnt_id;
         r_prio       <= ~w_gnt_id;
         r_rsp_result <= alu_result;
      end else if (w_rsp_fire) begin
         r_state      <= S_IDLE;
      end
   end

endmodule

// File: doc/ysyx_25010008_alu_arbiter.md
Name: ysyx_25010008_alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (req0 = EXU integer path, req1 = branch/compare path) with round-robin arbitration.
- Drives the ALU's opcode/operand inputs from the granted requester, registers the ALU result, and returns it to the winning requester through a valid/ready response channel.
- Allows one outstanding operation. Back-to-back issue is allowed in the cycle the pending response drains.

Parameters:
- FIRST_PRIO, 0, requester index favoured on the first contended cycle after reset (0 or 1).
- XLEN, 32, operand/result width. Must match the ALU.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  8  ALU opcode, one-hot-style ALU encoding
- req0_op1  in  XLEN  operand1
- req0_op2  in  XLEN  operand2
- rsp0_valid  out  1  result for requester 0 held
- rsp0_ready  in  1  requester 0 consumes result
- req1_valid, req1_ready, req1_opcode, req1_op1, req1_op2, rsp1_valid, rsp1_ready: same as the requester 0 ports, for requester 1
- rsp_result  out  XLEN  registered ALU result, valid when rsp0_valid or rsp1_valid
- alu_opcode  out  8  to ALU opcode
- alu_operand1  out  XLEN  to ALU operand1
- alu_operand2  out  XLEN  to ALU operand2
- alu_result  in  XLEN  from ALU result, combinational in the same cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- States:
  - IDLE: no result held.
  - HOLD: result held for rsp_id (1-bit register).
- can_accept = (state==IDLE) | (state==HOLD & rsp_fire). rsp_fire = rsp<rsp_id>_valid & rsp<rsp_id>_ready.
- Grant, combinational:
  - Only one reqN_valid: grant N.
  - Both valid: grant prio (1-bit).
  - None valid: no grant.
  - reqN_ready = can_accept & grant==N. reqN_ready does not depend on the other requester's ready.
- ALU drive:
  - With a grant, alu_opcode/operand1/operand2 = granted requester's fields, even if can_accept=0.
  - With no grant, all three are 0.
- Accept (reqN_valid & reqN_ready) at edge T:
  - rsp_result <= alu_result; rsp_id <= N; state <= HOLD; prio <= ~N.
  - rspN_valid is high from T+1. Latency is exactly 1 cycle.
- Response drain:
  - rsp_fire without a same-cycle accept: state <= IDLE. rsp_result keeps its value (don't-care).
  - rsp_fire with a same-cycle accept: stay HOLD with the new result/id. The valid may move to the other requester on the next cycle.
- Hold stability:
  - While HOLD and not fired, rsp_result and rsp_id are stable. rspN_valid stays high until ready.
  - No timeout; a stalled consumer blocks both requesters.
- rsp(1-rsp_id)_valid is always 0. At most one rsp valid at any time.
- Opcode and operands are passed through unmodified; the arbiter does not decode the opcode.
- Reset (reset_n=0 at an edge), including mid-HOLD:
  - state=IDLE, rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_id=0, prio=FIRST_PRIO.
  - Any held result is discarded.
  - During reset cycles req0_ready/req1_ready follow the combinational rule, but accepts are ignored.
- Requester valid may drop without ready (no protocol check). Operands are sampled only in the accept cycle.
- Round-robin fairness: under continuous contention with rsp ready tied high, grants alternate 0,1,0,1. Neither requester waits more than one accepted operation of the other.

Test Plan:
- Reset then single add: req0 opcode=0x00, op1=5, op2=7, valid for 1 cycle -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp_result=12, rsp1_valid=0.
- Subtract with held response: req1 opcode=0x01, op1=10, op2=3; rsp1_ready low 4 cycles -> rsp1_valid and rsp_result=7 stable for 4 cycles; req0_valid meanwhile -> req0_ready=0; after ready, IDLE.
- Contention with FIRST_PRIO=0: both valid continuously, rsp ready tied 1 -> grant order 0,1,0,1. One result per cycle, with rsp_result/rsp_id matching the granted requester's operands each cycle.
- Back-to-back across requesters: req0 accepted at T; at T+1 rsp0_ready=1 and req1 (signed compare opcode=0x21, op1=0xFFFFFFFF, op2=2) valid -> req1_ready=1 at T+1; at T+2 rsp0_valid=0, rsp1_valid=1, rsp_result=1.
- Reset mid-HOLD: accept req0 (op1=1, op2=1, add), hold rsp0_ready=0, assert reset_n=0 for 1 cycle -> next cycle rsp0_valid=0, rsp_result=0. A first contended request afterwards is granted to FIRST_PRIO.
- Idle drive: no valids -> alu_opcode=0, alu_operand1=0, alu_operand2=0, both req ready low? No: readiness of the idle requester is don't-care, and no rsp valid rises for 3 cycles.
